text_buffer_ctrl: RTL and testbench

Character-buffer controller that sits between the byte source (keyboard/UART receiver) and the text renderer. Holds the 32×4 character grid shown in the framed text window at x 192–447, y 208–271. It accepts bytes over a valid/ready handshake, interprets cursor-control codes, and performs wrap, scroll and clear as timed multi-cycle operations. It also supplies the renderer's `ascii_code` for the current beam position, with bit 7 passing through as the Thai/ASCII ROM select.

---
 rtl/text_buffer_ctrl.sv | 131 +++++++++++++
 tb/tb_text_buffer_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - character grid controller with cursor codes, timed scroll/clear sweeps and render read port
// Bytes arrive on a valid/ready handshake; the renderer reads cells by pixel position.
module text_buffer_ctrl #(
   parameter int         COLS  = 32,
   parameter int         ROWS  = 4,
   parameter int         X0    = 192,
   parameter int         Y0    = 208,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [7:0]                in_data,
   output logic                      in_ready,
   input  logic [9:0]                x,
   input  logic [9:0]                y,
   output logic [7:0]                ascii_code,
   output logic [$clog2(COLS)-1:0]   cursor_col,
   output logic [$clog2(ROWS)-1:0]   cursor_row,
   output logic                      busy
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int N  = COLS * ROWS;
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [7:0]    cells [N];

   logic          accept;
   logic          printable;
   logic [IW-1:0] cur;
   logic          in_win;
   logic [IW-1:0] rd_idx;

   always_comb begin
      accept    = in_valid && in_ready;
      printable = in_data[7] || (in_data >= 8'h20 && in_data <= 8'h7E);
      // COLS is a power of two, so {row,col} is row*COLS+col
      cur       = {cursor_row, cursor_col};
      in_win    = (x >= 10'(X0)) && (x < 10'(X0 + 8*COLS)) &&
                  (y >= 10'(Y0)) && (y < 10'(Y0 + 16*ROWS));
      rd_idx    = '0;
      if (in_win)
         rd_idx = {RW'((y - 10'(Y0)) >> 4), CW'((x - 10'(X0)) >> 3)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cursor_col <= '0;
         cursor_row <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         ascii_code <= BLANK;
         for (int i = 0; i < N; i++) cells[i] <= BLANK;
      end else begin
         ascii_code <= in_win ? cells[rd_idx] : BLANK;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (printable) begin
                     cells[cur] <= in_data;
                     if (cursor_col != CW'(COLS-1)) begin
                        cursor_col <= cursor_col + 1'b1;
                     end else begin
                        cursor_col <= '0;
                        if (cursor_row != RW'(ROWS-1)) begin
                           cursor_row <= cursor_row + 1'b1;
                        end else begin
                           state    <= SCROLL;
                           idx      <= '0;
                           in_ready <= 1'b0;
                           busy     <= 1'b1;
                        end
                     end
                  end else if (in_data == 8'h0A || in_data == 8'h0D) begin
                     cursor_col <= '0;
                     if (cursor_row != RW'(ROWS-1)) begin
                        cursor_row <= cursor_row + 1'b1;
                     end else begin
                        state    <= SCROLL;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                     end
                  end else if (in_data == 8'h08) begin
                     // stepping back one cell is cur-1 whether or not the row changes
                     if (cursor_col != '0) begin
                        cursor_col       <= cursor_col - 1'b1;
                        cells[cur-1'b1]  <= BLANK;
                     end else if (cursor_row != '0) begin
                        cursor_row       <= cursor_row - 1'b1;
                        cursor_col       <= CW'(COLS-1);
                        cells[cur-1'b1]  <= BLANK;
                     end
                  end else if (in_data == 8'h0C) begin
                     cursor_col <= '0;
                     cursor_row <= '0;
                     state      <= CLEAR;
                     idx        <= '0;
                     in_ready   <= 1'b0;
                     busy       <= 1'b1;
                  end
               end
            end
            default: begin
               if (state == SCROLL && idx < IW'(N-COLS))
                  cells[idx] <= cells[idx + IW'(COLS)];
               else
                  cells[idx] <= BLANK;
               if (idx == IW'(N-1)) begin
                  state    <= IDLE;
                  idx      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb/tb_text_buffer_ctrl.sv - directed self-checking bench for text_buffer_ctrl
// Cells are observed through the render port by steering x/y onto each character.
module tb_text_buffer_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [9:0] x, y;
   logic [7:0] ascii_code;
   logic [4:0] cursor_col;
   logic [1:0] cursor_row;
   logic       busy;

   int checks = 0;
   int errors = 0;

   text_buffer_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .x(x), .y(y), .ascii_code(ascii_code),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic read_cell(input int k, output logic [7:0] v);
      x = 10'(192 + 8*(k % 32));
      y = 10'(208 + 16*(k / 32));
      @(posedge clk); #1;
      v = ascii_code;
      x = '0;
      y = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; x = '0; y = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || ascii_code !== 8'h20 ||
          cursor_col !== 5'd0 || cursor_row !== 2'd0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b busy=%b ascii=%h cur=(%0d,%0d) want 0 0 20 (0,0)",
                  in_ready, busy, ascii_code, cursor_row, cursor_col);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
      read_cell(77, v);
      checks++;
      if (v !== 8'h20) begin
         errors++;
         $display("FAIL reset_cell77: got %h want 20", v);
      end
   endtask

   task automatic test_hello();
      logic [7:0] s [5];
      logic [7:0] v;
      s = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = s[i];
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hello_ready_%0d: got %b want 1", i, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (cursor_row !== 2'd0 || cursor_col !== 5'd5) begin
         errors++;
         $display("FAIL hello_cursor: got (%0d,%0d) want (0,5)", cursor_row, cursor_col);
      end
      for (int i = 0; i < 5; i++) begin
         read_cell(i, v);
         checks++;
         if (v !== s[i]) begin
            errors++;
            $display("FAIL hello_cell_%0d: got %h want %h", i, v, s[i]);
         end
      end
      x = 10'd200; y = 10'd210;
      @(posedge clk); #1;
      checks++;
      if (ascii_code !== 8'h45) begin
         errors++;
         $display("FAIL hello_render_200_210: got %h want 45", ascii_code);
      end
      x = 10'd100; y = 10'd210;
      @(posedge clk); #1;
      checks++;
      if (ascii_code !== 8'h20) begin
         errors++;
         $display("FAIL render_outside: got %h want 20", ascii_code);
      end
      x = '0; y = '0;
   endtask

   task automatic test_wrap_scroll();
      logic [7:0] v;
      logic [7:0] exp;
      int n;
      apply_reset();
      for (int i = 0; i < 96; i++) send(8'h41);
      checks++;
      if (cursor_row !== 2'd3 || cursor_col !== 5'd0) begin
         errors++;
         $display("FAIL wrap_cursor: got (%0d,%0d) want (3,0)", cursor_row, cursor_col);
      end
      for (int i = 0; i < 31; i++) send(8'h42);
      send(8'h43);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL scroll_start: busy=%b ready=%b want 1 0", busy, in_ready);
      end
      n = 0;
      while (busy && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != 128 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL scroll_length: got %0d cycles ready=%b want 128 1", n, in_ready);
      end
      for (int k = 0; k < 128; k++) begin
         if (k < 64)      exp = 8'h41;
         else if (k < 95) exp = 8'h42;
         else if (k == 95) exp = 8'h43;
         else             exp = 8'h20;
         read_cell(k, v);
         checks++;
         if (v !== exp) begin
            errors++;
            $display("FAIL scroll_cell_%0d: got %h want %h", k, v, exp);
         end
      end
      checks++;
      if (cursor_row !== 2'd3 || cursor_col !== 5'd0) begin
         errors++;
         $display("FAIL scroll_cursor: got (%0d,%0d) want (3,0)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_backspace();
      logic [7:0] v;
      apply_reset();
      for (int i = 0; i < 32; i++) send(8'h44);
      send(8'h08);
      checks++;
      if (cursor_row !== 2'd0 || cursor_col !== 5'd31) begin
         errors++;
         $display("FAIL bs_cursor: got (%0d,%0d) want (0,31)", cursor_row, cursor_col);
      end
      read_cell(31, v);
      checks++;
      if (v !== 8'h20) begin
         errors++;
         $display("FAIL bs_cell31: got %h want 20", v);
      end
      read_cell(30, v);
      checks++;
      if (v !== 8'h44) begin
         errors++;
         $display("FAIL bs_cell30: got %h want 44", v);
      end
      for (int i = 0; i < 33; i++) send(8'h08);
      checks++;
      if (cursor_row !== 2'd0 || cursor_col !== 5'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bs_origin: got (%0d,%0d) ready=%b want (0,0) 1", cursor_row, cursor_col, in_ready);
      end
      read_cell(0, v);
      checks++;
      if (v !== 8'h20) begin
         errors++;
         $display("FAIL bs_cell0: got %h want 20", v);
      end
      send(8'h01);
      send(8'h7F);
      send(8'h0D);
      checks++;
      if (cursor_row !== 2'd1 || cursor_col !== 5'd0) begin
         errors++;
         $display("FAIL ignore_then_cr: got (%0d,%0d) want (1,0)", cursor_row, cursor_col);
      end
      read_cell(0, v);
      checks++;
      if (v !== 8'h20) begin
         errors++;
         $display("FAIL ignored_not_stored: got %h want 20", v);
      end
   endtask

   task automatic test_form_feed();
      logic [7:0] v;
      int n;
      int bad;
      apply_reset();
      for (int i = 0; i < 40; i++) send(8'h45);
      send(8'h0C);
      n = 0;
      while (!in_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != 128) begin
         errors++;
         $display("FAIL ff_length: got %0d cycles want 128", n);
      end
      bad = 0;
      for (int k = 0; k < 128; k++) begin
         read_cell(k, v);
         if (v !== 8'h20) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ff_cells: got %0d non-blank cells want 0", bad);
      end
      checks++;
      if (cursor_row !== 2'd0 || cursor_col !== 5'd0) begin
         errors++;
         $display("FAIL ff_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_stall();
      logic [7:0] v;
      int n;
      apply_reset();
      for (int i = 0; i < 4; i++) send(8'h0A);
      in_valid = 1'b1;
      in_data  = 8'h58;
      n = 0;
      while (!in_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != 128 || cursor_col !== 5'd0 || cursor_row !== 2'd3) begin
         errors++;
         $display("FAIL stall_wait: got %0d cycles cur=(%0d,%0d) want 128 (3,0)", n, cursor_row, cursor_col);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (cursor_row !== 2'd3 || cursor_col !== 5'd1) begin
         errors++;
         $display("FAIL stall_cursor: got (%0d,%0d) want (3,1)", cursor_row, cursor_col);
      end
      read_cell(96, v);
      checks++;
      if (v !== 8'h58) begin
         errors++;
         $display("FAIL stall_cell96: got %h want 58", v);
      end
      read_cell(97, v);
      checks++;
      if (v !== 8'h20) begin
         errors++;
         $display("FAIL stall_cell97: got %h want 20", v);
      end
   endtask

   task automatic test_thai_reset();
      logic [7:0] v;
      apply_reset();
      send(8'hA1);
      read_cell(0, v);
      checks++;
      if (v !== 8'hA1 || v[7] !== 1'b1) begin
         errors++;
         $display("FAIL thai_cell0: got %h want a1", v);
      end
      for (int i = 0; i < 3; i++) send(8'h0A);
      send(8'h5A);
      send(8'h0C);
      repeat (60) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || ascii_code !== 8'h20 ||
          cursor_col !== 5'd0 || cursor_row !== 2'd0) begin
         errors++;
         $display("FAIL midsweep_reset: busy=%b ready=%b ascii=%h cur=(%0d,%0d) want 0 0 20 (0,0)",
                  busy, in_ready, ascii_code, cursor_row, cursor_col);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midsweep_idle: ready=%b busy=%b want 1 0", in_ready, busy);
      end
      read_cell(96, v);
      checks++;
      if (v !== 8'h20) begin
         errors++;
         $display("FAIL midsweep_cell96: got %h want 20", v);
      end
   endtask

   initial begin
      test_reset();
      test_hello();
      test_wrap_scroll();
      test_backspace();
      test_form_feed();
      test_stall();
      test_thai_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
